rca_pipe: RTL

- Parametrised, pipelined ripple-carry adder/subtractor; the next generation of the fixed-width combinational ripple-carry adders.
- Splits a WIDTH-bit add into STAGES slices. Each slice ripples combinationally inside one pipeline stage, and the carry is registered between stages.
- Adds a valid/ready handshake, add/subtract mode, carry/borrow-in, and signed overflow.
- Sits between operand sources and the datapath ALU where the full-width combinational ripple cannot close timing.

---
 rtl/rca_pipe.sv | 100 ++++++++++
 1 files changed

// File: rtl/rca_pipe.sv
// Pipelined ripple-carry adder/subtractor. Each stage ripples one SLICE-bit
// slice and hands its carry, the operands and the partial sum to the next stage.
module rca_pipe #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             carry_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow
);

  localparam int SLICE = WIDTH / STAGES;

  logic             adv;
  logic             v_q [STAGES];
  logic             c_q [STAGES];
  logic [WIDTH-1:0] a_q [STAGES];
  logic [WIDTH-1:0] b_q [STAGES];
  logic [WIDTH-1:0] s_q [STAGES];
  logic             ov_q;

  // The whole pipe moves in lockstep: any empty or draining output lets it shift.
  assign adv      = !v_q[STAGES-1] || out_ready;
  assign in_ready = adv;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      logic             src_v;
      logic             src_c;
      logic [WIDTH-1:0] src_a;
      logic [WIDTH-1:0] src_b;
      logic [WIDTH-1:0] src_s;
      logic [SLICE:0]   t;

      if (k == 0) begin : g_in
        // Subtract as a + ~b + ~borrow; carry_out then reads as "no borrow".
        assign src_v = in_valid;
        assign src_a = a;
        assign src_b = sub ? ~b : b;
        assign src_c = sub ^ carry_in;
        assign src_s = '0;
      end else begin : g_chain
        assign src_v = v_q[k-1];
        assign src_a = a_q[k-1];
        assign src_b = b_q[k-1];
        assign src_c = c_q[k-1];
        assign src_s = s_q[k-1];
      end

      assign t = {1'b0, src_a[k*SLICE +: SLICE]}
               + {1'b0, src_b[k*SLICE +: SLICE]}
               + {{SLICE{1'b0}}, src_c};

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q[k] <= 1'b0;
          c_q[k] <= 1'b0;
          a_q[k] <= '0;
          b_q[k] <= '0;
          s_q[k] <= '0;
        end else if (adv) begin
          v_q[k] <= src_v;
          c_q[k] <= t[SLICE];
          a_q[k] <= src_a;
          b_q[k] <= src_b;
          s_q[k] <= src_s;
          s_q[k][k*SLICE +: SLICE] <= t[SLICE-1:0];
        end
      end

      if (k == STAGES - 1) begin : g_flag
        // Carry into the MSB is recovered as a ^ b ^ sum at that bit.
        always_ff @(posedge clk or negedge rst_n) begin
          if (!rst_n) begin
            ov_q <= 1'b0;
          end else if (adv) begin
            ov_q <= src_a[WIDTH-1] ^ src_b[WIDTH-1] ^ t[SLICE-1] ^ t[SLICE];
          end
        end
      end
    end
  endgenerate

  assign out_valid = v_q[STAGES-1];
  assign sum       = s_q[STAGES-1];
  assign carry_out = c_q[STAGES-1];
  assign overflow  = ov_q;

endmodule
